key_expansion_logic: RTL and testbench

KEY_EXPANSION_LOGIC -- requirements
Module: key_expansion_logic

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_sbox.sv | 18 +
 rtl/key_expansion_logic.sv | 59 +++++
 tb/tb_key_expansion_logic.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : shared AES-128 constants (widths, forward S-box, rcon sequence)
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int KEY_W      = 128;
  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int NUM_ROUNDS = 10;

  // FIPS-197 forward S-box, indexed by the input byte
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants for rounds 1..10, for the sequencer one level up
  localparam logic [WORD_W-1:0] RCON [NUM_ROUNDS] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
  };

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage : aes_pkg

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// aes_sbox : combinational AES forward S-box, pure table lookup
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = SBOX[byte_i];

endmodule : aes_sbox

`default_nettype wire

// File: rtl/key_expansion_logic.sv
// ============================================================================
// key_expansion_logic : one AES-128 key-schedule round, registered output
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_expansion_logic
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_enable,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [WORD_W-1:0] rcon_in,
  output logic [KEY_W-1:0]  key_out
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot_w, sub_w, temp_w;
  logic [WORD_W-1:0] n0, n1, n2, n3;
  logic [KEY_W-1:0]  key_d, key_q;

  assign {w0, w1, w2, w3} = key_in;
  assign rot_w            = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_i (rot_w[i*BYTE_W +: BYTE_W]),
      .byte_o (sub_w[i*BYTE_W +: BYTE_W])
    );
  end

  // rcon is applied as a full word so non-standard constants pass through unchanged
  assign temp_w = sub_w ^ rcon_in;
  assign n0     = w0 ^ temp_w;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  always_comb begin
    key_d = key_q;
    if (load_enable) begin
      key_d = {n0, n1, n2, n3};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q <= '0;
    end else begin
      key_q <= key_d;
    end
  end

  assign key_out = key_q;

endmodule : key_expansion_logic

`default_nettype wire

// File: tb/tb_key_expansion_logic.sv
// ============================================================================
// tb_key_expansion_logic : randomized self-checking bench, GF(2^8) reference
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_expansion_logic;

  logic         clk;
  logic         rst;
  logic         load_enable;
  logic [127:0] key_in;
  logic [31:0]  rcon_in;
  logic [127:0] key_out;

  int n_checks;
  int n_errors;

  logic [7:0]   sb_ref [256];
  logic [127:0] exp_key;

  key_expansion_logic u_dut (
    .clk         (clk),
    .rst         (rst),
    .load_enable (load_enable),
    .key_in      (key_in),
    .rcon_in     (rcon_in),
    .key_out     (key_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%032h exp=%032h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box derived from the field inverse and affine map, independent of any table
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      end
      sb_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_next(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] w [4];
    logic [31:0] n [4];
    logic [31:0] t;
    logic [31:0] prev;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    t = {sb_ref[w[3][23:16]], sb_ref[w[3][15:8]], sb_ref[w[3][7:0]], sb_ref[w[3][31:24]]} ^ rc;
    prev = t;
    for (int i = 0; i < 4; i++) begin
      n[i] = w[i] ^ prev;
      prev = n[i];
    end
    return {n[0], n[1], n[2], n[3]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [31:0] rand_rcon();
    logic [7:0] rc = 8'h01;
    int r = $urandom_range(0, 12);
    if (r > 9) return $urandom();
    for (int i = 0; i < r; i++) rc = gf_mul(rc, 8'h02);
    return {rc, 24'h0};
  endfunction

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    load_enable = 1'b0;
    key_in      = '0;
    rcon_in     = '0;
    build_sbox();

    #3 rst = 1'b0;
    #1 chk("reset_async", key_out, 128'h0);
    load_enable = 1'b1;
    key_in      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rcon_in     = 32'h01000000;
    repeat (2) @(negedge clk);
    chk("reset_priority", key_out, 128'h0);
    load_enable = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    chk("no_load_after_reset", key_out, 128'h0);

    load_enable = 1'b1;
    @(negedge clk);
    chk("fips_round1", key_out, 128'ha0fafe1788542cb123a339392a6c7605);
    key_in  = 128'ha0fafe1788542cb123a339392a6c7605;
    rcon_in = 32'h02000000;
    @(negedge clk);
    chk("fips_round2", key_out, 128'hf2c295f27a96b9435935807a7359f67f);
    key_in  = 128'h0;
    rcon_in = 32'h01000000;
    @(negedge clk);
    chk("zero_key", key_out, 128'h62636363626363636263636362636363);

    load_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key_in  = rand128();
      rcon_in = $urandom();
      @(negedge clk);
      chk("hold", key_out, 128'h62636363626363636263636362636363);
    end

    @(posedge clk);
    load_enable = 1'b1;
    key_in      = rand128();
    #2 rst = 1'b0;
    #1 chk("midstream_reset_async", key_out, 128'h0);
    repeat (3) @(negedge clk);
    chk("midstream_reset_hold", key_out, 128'h0);
    load_enable = 1'b0;
    rst         = 1'b1;
    exp_key     = 128'h0;

    for (int i = 0; i < 100; i++) begin
      key_in      = rand128();
      rcon_in     = rand_rcon();
      load_enable = 1'b1;
      exp_key     = ref_next(key_in, rcon_in);
      @(negedge clk);
      chk("random_stream", key_out, exp_key);
    end

    for (int i = 0; i < 60; i++) begin
      key_in      = rand128();
      rcon_in     = rand_rcon();
      load_enable = ($urandom_range(0, 3) != 0);
      if (load_enable) exp_key = ref_next(key_in, rcon_in);
      @(negedge clk);
      chk("random_enable", key_out, exp_key);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_key_expansion_logic

`default_nettype wire
